// File: rtl/bw_io_dtl_rcv_dglitch_pkg.sv
// Shared definitions for the DTL receiver deglitch path: FSM state encodings
// and the width helper used to size the debounce counter.
package bw_io_dtl_rcv_dglitch_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_PEND   = 1'b1
   } dg_state_e;

   // Ceiling log2 with a floor of 1 bit so a counter never collapses to zero width.
   function automatic int clog2_f(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/bw_io_dtl_rcv_dglitch_if.sv
// Signal bundle between the receiver/CSR side and the deglitch block.
interface bw_io_dtl_rcv_dglitch_if #(
   parameter int CNT_W = 8
);
   logic             rcv_in;
   logic             filt_en;
   logic             clr_cnt;
   logic             out;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] glitch_cnt;

   modport master (
      output rcv_in, filt_en, clr_cnt,
      input  out, rise, fall, glitch_cnt
   );

   modport slave (
      input  rcv_in, filt_en, clr_cnt,
      output out, rise, fall, glitch_cnt
   );
endinterface

// File: rtl/bw_io_dtl_rcv_dglitch_sync.sv
// Parameterised N-flop synchroniser with a configurable reset value; shared by
// the JBUS pad receive paths.
module bw_io_dtl_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bw_io_dtl_rcv_dglitch.sv
// Deglitch/edge-detect stage after the DTL/HSTL sense amp: synchronise, debounce
// with a consecutive-sample filter, emit level plus rise/fall pulses and a glitch count.
module bw_io_dtl_rcv_dglitch
   import bw_io_dtl_rcv_dglitch_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   DEB_CYCLES  = 4,
   parameter int   CNT_W       = 8,
   parameter logic RESET_VAL   = 1'b0
) (
   input logic                    clk,
   input logic                    rst,
   bw_io_dtl_rcv_dglitch_if.slave bus
);

   localparam int               DEB_W   = clog2_f(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam bit               DEB_ONE = (DEB_CYCLES == 1);

   logic             sync_q;
   dg_state_e        state_q, state_d;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d, deb_inc;
   logic             out_q, out_d;
   logic             rise_q, fall_q;
   logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
   logic             glitch_inc;
   logic             mismatch;
   logic             deb_hit;

   bw_io_dtl_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (RESET_VAL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.rcv_in),
      .q_o (sync_q)
   );

   assign mismatch = sync_q ^ out_q;
   assign deb_inc  = deb_cnt_q + DEB_W'(1);
   assign deb_hit  = (deb_inc == DEB_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STABLE;
      end else begin
         state_q <= state_d;
      end
   end

   // With DEB_CYCLES==1 the first mismatch already flips out, so PEND is never entered.
   always_comb begin
      state_d = state_q;
      if (!bus.filt_en) begin
         state_d = ST_STABLE;
      end else begin
         case (state_q)
            ST_STABLE: if (mismatch && !DEB_ONE) state_d = ST_PEND;
            ST_PEND:   if (!mismatch || deb_hit) state_d = ST_STABLE;
            default:   state_d = ST_STABLE;
         endcase
      end
   end

   // Dropping filt_en or taking reset mid-PEND discards the run without counting it.
   always_comb begin
      out_d      = out_q;
      deb_cnt_d  = '0;
      glitch_inc = 1'b0;
      if (!bus.filt_en) begin
         out_d = sync_q;
      end else begin
         case (state_q)
            ST_STABLE: begin
               if (mismatch) begin
                  if (DEB_ONE) out_d = sync_q;
                  else         deb_cnt_d = DEB_W'(1);
               end
            end
            ST_PEND: begin
               if (!mismatch)    glitch_inc = 1'b1;
               else if (deb_hit) out_d = sync_q;
               else              deb_cnt_d = deb_inc;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      glitch_cnt_d = glitch_cnt_q;
      if (bus.clr_cnt) begin
         glitch_cnt_d = '0;
      end else if (glitch_inc && (glitch_cnt_q != CNT_SAT)) begin
         glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= RESET_VAL;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         deb_cnt_q    <= '0;
         glitch_cnt_q <= '0;
      end else begin
         out_q        <= out_d;
         rise_q       <= out_d & ~out_q;
         fall_q       <= ~out_d & out_q;
         deb_cnt_q    <= deb_cnt_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign bus.out        = out_q;
   assign bus.rise       = rise_q;
   assign bus.fall       = fall_q;
   assign bus.glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_bw_io_dtl_rcv_dglitch.sv
// Bench for bw_io_dtl_rcv_dglitch: two configurations driven by shared stimulus,
// checked each cycle against a run-length reference model plus directed checks.
module tb_bw_io_dtl_rcv_dglitch;

   logic clk = 1'b0;
   logic rst_r, rcv, filt, clr;

   always #5 clk = ~clk;

   bw_io_dtl_rcv_dglitch_if #(.CNT_W(8)) bus0 ();
   bw_io_dtl_rcv_dglitch_if #(.CNT_W(4)) bus1 ();

   assign bus0.rcv_in  = rcv;
   assign bus0.filt_en = filt;
   assign bus0.clr_cnt = clr;
   assign bus1.rcv_in  = rcv;
   assign bus1.filt_en = filt;
   assign bus1.clr_cnt = clr;

   bw_io_dtl_rcv_dglitch #(
      .SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(8), .RESET_VAL(1'b0)
   ) dut0 (
      .clk(clk), .rst(rst_r), .bus(bus0)
   );

   bw_io_dtl_rcv_dglitch #(
      .SYNC_STAGES(3), .DEB_CYCLES(1), .CNT_W(4), .RESET_VAL(1'b1)
   ) dut1 (
      .clk(clk), .rst(rst_r), .bus(bus1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: out flips once the synced input has disagreed with it for DEB
   // consecutive samples; a disagreeing run that ends early is one glitch.
   logic [3:0] m_hist [2];
   logic       m_out  [2];
   logic       m_rise [2];
   logic       m_fall [2];
   int         m_run  [2];
   int         m_cnt  [2];

   task automatic model_step(input int k, input int sn, input int deb, input int cmax, input logic rv);
      logic s, old;
      bit   g;
      if (rst_r) begin
         m_hist[k] = {4{rv}};
         m_out[k]  = rv;
         m_rise[k] = 1'b0;
         m_fall[k] = 1'b0;
         m_run[k]  = 0;
         m_cnt[k]  = 0;
      end else begin
         s         = m_hist[k][sn-1];
         m_hist[k] = {m_hist[k][2:0], rcv};
         old       = m_out[k];
         g         = 1'b0;
         if (!filt) begin
            m_out[k] = s;
            m_run[k] = 0;
         end else if (s != m_out[k]) begin
            m_run[k]++;
            if (m_run[k] >= deb) begin
               m_out[k] = s;
               m_run[k] = 0;
            end
         end else begin
            g        = (m_run[k] > 0);
            m_run[k] = 0;
         end
         if (clr) m_cnt[k] = 0;
         else if (g && m_cnt[k] < cmax) m_cnt[k]++;
         m_rise[k] = m_out[k] & ~old;
         m_fall[k] = ~m_out[k] & old;
      end
   endtask

   int r0, f0;

   task automatic step();
      @(posedge clk);
      model_step(0, 2, 4, 255, 1'b0);
      model_step(1, 3, 1, 15, 1'b1);
      #1;
      check_val("d0_out",  bus0.out,        m_out[0]);
      check_val("d0_rise", bus0.rise,       m_rise[0]);
      check_val("d0_fall", bus0.fall,       m_fall[0]);
      check_val("d0_cnt",  bus0.glitch_cnt, m_cnt[0]);
      check_val("d1_out",  bus1.out,        m_out[1]);
      check_val("d1_rise", bus1.rise,       m_rise[1]);
      check_val("d1_fall", bus1.fall,       m_fall[1]);
      check_val("d1_cnt",  bus1.glitch_cnt, m_cnt[1]);
      if (bus0.rise) r0++;
      if (bus0.fall) f0++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int first_k;
   int c_before;
   int cyc;
   int len;

   initial begin
      rst_r = 1'b1; rcv = 1'b1; filt = 1'b1; clr = 1'b0;
      r0 = 0; f0 = 0;

      // Reset held with rcv_in high, then release.
      run(3);
      check_val("rst_out0", bus0.out, 0);
      check_val("rst_cnt0", bus0.glitch_cnt, 0);
      rst_r = 1'b0;
      r0 = 0; first_k = -1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (first_k < 0 && bus0.out === 1'b1) first_k = k;
      end
      check_val("rel_latency", first_k, 6);
      check_val("rel_rise_cnt", r0, 1);

      // Filtered 1->0 step.
      rcv = 1'b0; f0 = 0; first_k = -1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (first_k < 0 && bus0.out === 1'b0) first_k = k;
      end
      check_val("filt_fall_latency", first_k, 6);
      check_val("filt_fall_cnt", f0, 1);

      // Bypass 1->0 step.
      filt = 1'b0; rcv = 1'b1;
      run(8);
      rcv = 1'b0; f0 = 0; first_k = -1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (first_k < 0 && bus0.out === 1'b0) first_k = k;
      end
      check_val("byp_fall_latency", first_k, 3);
      check_val("byp_fall_cnt", f0, 1);

      // Three-sample glitch is rejected and counted.
      filt = 1'b1;
      run(4);
      clr = 1'b1; step(); clr = 1'b0;
      rcv = 1'b1; r0 = 0; run(3);
      rcv = 1'b0; run(10);
      check_val("glitch_cnt1", bus0.glitch_cnt, 1);
      check_val("glitch_norise", r0, 0);
      check_val("glitch_out", bus0.out, 0);

      // Saturation with back-to-back 2-sample glitches.
      clr = 1'b1; step(); clr = 1'b0;
      for (int g = 0; g < 300; g++) begin
         rcv = 1'b1; run(2);
         rcv = 1'b0; run(2);
      end
      run(4);
      check_val("sat_cnt", bus0.glitch_cnt, 255);

      // Clear held across glitch increments wins.
      clr = 1'b1;
      for (int g = 0; g < 5; g++) begin
         rcv = 1'b1; run(2);
         rcv = 1'b0; run(2);
      end
      run(4);
      check_val("clr_wins", bus0.glitch_cnt, 0);
      clr = 1'b0; run(3);
      check_val("clr_hold", bus0.glitch_cnt, 0);

      // filt_en dropped while a transition is pending.
      c_before = bus0.glitch_cnt;
      rcv = 1'b1; run(3);
      filt = 1'b0; rcv = 1'b0; run(5);
      filt = 1'b1; run(6);
      check_val("filt_drop_nocnt", bus0.glitch_cnt, c_before);

      // Reset while a transition is pending.
      rcv = 1'b1; run(3);
      rst_r = 1'b1; step();
      rst_r = 1'b0; rcv = 1'b0; r0 = 0; run(6);
      check_val("rst_pend_cnt", bus0.glitch_cnt, 0);
      check_val("rst_pend_out", bus0.out, 0);
      check_val("rst_pend_norise", r0, 0);

      // Single-sample mismatch on the DEB_CYCLES=1, 3-stage instance.
      rcv = 1'b1; run(10);
      first_k = -1;
      for (int k = 1; k <= 8; k++) begin
         rcv = (k == 1) ? 1'b0 : 1'b1;
         step();
         if (first_k < 0 && bus1.out === 1'b0) first_k = k;
      end
      check_val("deb1_latency", first_k, 4);

      // Randomised segments with occasional bypass, clears and resets.
      cyc = 0;
      while (cyc < 2500) begin
         len  = $urandom_range(1, 8);
         rcv  = 1'($urandom_range(0, 1));
         filt = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < len; i++) begin
            clr   = ($urandom_range(0, 19) == 0);
            rst_r = ($urandom_range(0, 149) == 0);
            step();
         end
         cyc += len;
      end
      rst_r = 1'b0; clr = 1'b0; filt = 1'b1;
      run(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
